// File: rtl/aes_spi_pkg.sv
// aes_spi_pkg: shared types and constants for the AES SPI link.
//   link_state_t : link FSM state encoding
//   FRAME_BITS   : bits in one {plaintext,key} frame
//   CT_BITS      : bits in one cyphertext readout
//   CNT_W        : width of the rx/tx bit counters (holds 0..FRAME_BITS)
package aes_spi_pkg;

    localparam int FRAME_BITS = 256;
    localparam int CT_BITS    = 128;
    localparam int CNT_W      = 9;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        START,
        WAIT,
        SEND
    } link_state_t;

endpackage

// File: rtl/spi_pin_sync.sv
// spi_pin_sync: brings one asynchronous MCU pin into the clk domain.
//   clk, reset : system clock, asynchronous active-high reset
//   pin        : raw asynchronous input
//   level      : synchronised level (SYNC_STAGES flops after the pin)
//   rise, fall : one-clk pulses on a synchronised 0->1 / 1->0 transition
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the value from before the edge, regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            last_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
            last_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~last_q;
    assign fall  = ~level & last_q;

endmodule

// File: rtl/aes_spi_link.sv
// aes_spi_link: SPI slave front end for the AES accelerator.
//   clk, reset  : system clock, asynchronous active-high reset
//   sck/sdi     : SPI clock and data from the MCU (asynchronous)
//   load        : frame strobe, high while a frame is clocked in; falling = go
//   sdo         : cyphertext out, MSB first, updated after sck falling
//   done        : cyphertext ready for readout
//   rx_err      : last frame was not exactly 2*BLK_W bits
//   plaintext   : first BLK_W bits of the frame, key : last BLK_W bits
//   core_start  : one-clk start pulse to aes_core
//   core_done   : aes_core finished (level or pulse), core_ct valid with it
module aes_spi_link
    import aes_spi_pkg::*;
#(
    parameter int BLK_W       = CT_BITS,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sck,
    input  logic             sdi,
    input  logic             load,
    output logic             sdo,
    output logic             done,
    output logic             rx_err,
    output logic [BLK_W-1:0] plaintext,
    output logic [BLK_W-1:0] key,
    output logic             core_start,
    input  logic             core_done,
    input  logic [BLK_W-1:0] core_ct
);

    localparam int FRAME_W = 2 * BLK_W;
    localparam int CW      = $clog2(FRAME_W + 1);
    localparam logic [CW-1:0] FRAME_LEN = CW'(FRAME_W);
    localparam logic [CW-1:0] TX_LEN    = CW'(BLK_W);

    logic sck_rise, sck_fall, sck_level;
    logic sdi_s, sdi_rise, sdi_fall;
    logic load_s, load_rise, load_fall;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
        .clk(clk), .reset(reset), .pin(sck),
        .level(sck_level), .rise(sck_rise), .fall(sck_fall)
    );
    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdi (
        .clk(clk), .reset(reset), .pin(sdi),
        .level(sdi_s), .rise(sdi_rise), .fall(sdi_fall)
    );
    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_load (
        .clk(clk), .reset(reset), .pin(load),
        .level(load_s), .rise(load_rise), .fall(load_fall)
    );

    // Edge pulses of sdi and the sck level are not needed by the link.
    logic unused_sync;
    assign unused_sync = ^{sdi_rise, sdi_fall, sck_level};

    link_state_t          state, state_nxt;
    logic [FRAME_W-1:0]   rx_sr;
    logic [BLK_W-1:0]     tx_sr;
    logic [CW-1:0]        rx_cnt, tx_cnt;
    logic                 overrun;
    logic                 take_bit, extra_bit, frame_ok;

    // A bit arriving in the same clk as load_fall is taken before the length
    // check, so frame_ok looks at the count as it will be after this edge.
    assign take_bit  = (state == RECV) && sck_rise && (rx_cnt < FRAME_LEN);
    assign extra_bit = (state == RECV) && sck_rise && (rx_cnt == FRAME_LEN);
    assign frame_ok  = ((rx_cnt == FRAME_LEN) ||
                        (take_bit && (rx_cnt == FRAME_LEN - CW'(1)))) &&
                       !overrun && !extra_bit;

    // NOTE: state_nxt gets a default before the case so no path through the
    // block leaves it unassigned, which would infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (load_s) state_nxt = RECV;
            RECV:  if (load_fall) state_nxt = frame_ok ? START : IDLE;
            START: state_nxt = load_rise ? RECV : WAIT;
            WAIT: begin
                if (load_rise)      state_nxt = RECV;
                else if (core_done) state_nxt = SEND;
            end
            SEND:  if (load_rise) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: the shift registers are reset as well as the control state, so a
    // reset mid-frame leaves no partial frame visible on plaintext/key.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            rx_sr   <= '0;
            tx_sr   <= '0;
            rx_cnt  <= '0;
            tx_cnt  <= '0;
            overrun <= 1'b0;
            done    <= 1'b0;
            rx_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (load_s) begin
                        rx_cnt  <= '0;
                        overrun <= 1'b0;
                        done    <= 1'b0;
                        rx_err  <= 1'b0;
                    end
                end
                RECV: begin
                    if (take_bit) begin
                        rx_sr  <= {rx_sr[FRAME_W-2:0], sdi_s};
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                    if (extra_bit) overrun <= 1'b1;
                    if (load_fall && !frame_ok) rx_err <= 1'b1;
                end
                START, WAIT: begin
                    if (load_rise) begin
                        // Abort: restart reception, drop any pending result.
                        rx_cnt  <= '0;
                        overrun <= 1'b0;
                    end else if (state == WAIT && core_done) begin
                        tx_sr  <= core_ct;
                        tx_cnt <= '0;
                        done   <= 1'b1;
                    end
                end
                SEND: begin
                    if (load_rise) begin
                        done  <= 1'b0;
                        tx_sr <= '0;
                    end else if (sck_fall && tx_cnt < TX_LEN) begin
                        // The 128th shift empties tx_sr, so sdo rests at 0.
                        tx_sr  <= {tx_sr[BLK_W-2:0], 1'b0};
                        tx_cnt <= tx_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign core_start = (state == START);
    assign sdo        = tx_sr[BLK_W-1];
    assign plaintext  = rx_sr[FRAME_W-1:BLK_W];
    assign key        = rx_sr[BLK_W-1:0];

endmodule

// File: tb/tb_aes_spi_link.sv
// tb_aes_spi_link: self-checking bench for aes_spi_link.
// Frames are clocked in through the SPI pins, a modelled aes_core answers
// with a known cyphertext, and the MCU side reads it back bit by bit.
module tb_aes_spi_link;

    localparam int SYNC = 2;

    localparam logic [127:0] FIPS_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] C1_PT    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_KEY   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         sck = 1'b0;
    logic         sdi = 1'b0;
    logic         load = 1'b0;
    logic         core_done = 1'b0;
    logic [127:0] core_ct = '0;
    logic         sdo, done, rx_err, core_start;
    logic [127:0] plaintext, key;

    aes_spi_link #(.BLK_W(128), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .reset(reset), .sck(sck), .sdi(sdi), .load(load),
        .sdo(sdo), .done(done), .rx_err(rx_err),
        .plaintext(plaintext), .key(key),
        .core_start(core_start), .core_done(core_done), .core_ct(core_ct)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    logic exp_q[$];

    always @(negedge clk) if (core_start) start_cnt++;

    typedef struct {
        string        name;
        logic [127:0] pt;
        logic [127:0] key;
        int           nbits;
        bit           same_edge;
        logic         exp_err;
        int           exp_starts;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        sdi = b;
        tick(4);
        sck = 1'b1;
        tick(4);
        sck = 1'b0;
    endtask

    // Raise load, clock nbits of {frame} MSB first, drop load; lat returns the
    // number of clk rising edges from the load pin falling to core_start.
    task automatic load_frame(input logic [255:0] frame, input int nbits,
                              input bit same_edge, output int lat);
        logic [256:0] fr;
        fr   = {frame, 1'b1};
        load = 1'b1;
        tick(6);
        for (int i = 0; i < nbits; i++) begin
            if (same_edge && i == nbits - 1) begin
                sdi = fr[256-i];
                tick(4);
                sck  = 1'b1;
                load = 1'b0;
            end else begin
                send_bit(fr[256-i]);
            end
        end
        if (!same_edge) begin
            tick(4);
            load = 1'b0;
        end
        lat = -1;
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            if (core_start && lat < 0) lat = k;
            if (k == 4) sck = 1'b0;
        end
    endtask

    // Model aes_core: core_done pulse with the cyphertext, readout bits queued.
    task automatic deliver(input logic [127:0] ct);
        tick(20);
        check("done_before_core", done, 1'b0);
        core_done = 1'b1;
        core_ct   = ct;
        for (int i = 127; i >= 0; i--) exp_q.push_back(ct[i]);
        tick(1);
        core_done = 1'b0;
        core_ct   = 128'($urandom);
        check("done_1clk", done, 1'b1);
        check("sdo_msb_with_done", sdo, ct[127]);
    endtask

    task automatic read_ct(output logic [127:0] got);
        logic b, e;
        got = '0;
        for (int i = 0; i < 128; i++) begin
            tick(4);
            b = sdo;
            if (exp_q.size() == 0) begin
                check("sdo_queue_empty", 1'b1, 1'b0);
                e = 1'bx;
            end else begin
                e = exp_q.pop_front();
                check("sdo_bit", b, e);
            end
            got = {got[126:0], b};
            sck = 1'b1;
            tick(4);
            sck = 1'b0;
        end
        tick(4);
        check("sdo_zero_after_128", sdo, 1'b0);
    endtask

    initial begin
        int           s0, lat;
        logic [127:0] got;

        vecs[0] = '{"fips_a1",      FIPS_PT, FIPS_KEY, 256, 1'b0, 1'b0, 1};
        vecs[1] = '{"short_255",    FIPS_PT, FIPS_KEY, 255, 1'b0, 1'b1, 0};
        vecs[2] = '{"long_257",     C1_PT,   C1_KEY,   257, 1'b0, 1'b1, 0};
        vecs[3] = '{"c1_same_edge", C1_PT,   C1_KEY,   256, 1'b1, 1'b0, 1};
        vecs[4] = '{"fips_again",   FIPS_PT, FIPS_KEY, 256, 1'b0, 1'b0, 1};

        // Reset state
        tick(2);
        check("rst_sdo", sdo, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_rx_err", rx_err, 1'b0);
        check("rst_core_start", core_start, 1'b0);
        check("rst_plaintext", plaintext, 128'h0);
        check("rst_key", key, 128'h0);
        reset = 1'b0;
        tick(2);

        // Table of frames: good, short, long, bit-on-load-fall, good
        foreach (vecs[v]) begin
            s0 = start_cnt;
            load_frame({vecs[v].pt, vecs[v].key}, vecs[v].nbits, vecs[v].same_edge, lat);
            check({vecs[v].name, "_rx_err"}, rx_err, vecs[v].exp_err);
            check({vecs[v].name, "_starts"}, 256'(start_cnt - s0), 256'(vecs[v].exp_starts));
            if (vecs[v].exp_err) begin
                // Link must be idle: a core_done now is ignored.
                core_done = 1'b1;
                core_ct   = C1_CT;
                tick(1);
                core_done = 1'b0;
                tick(2);
                check({vecs[v].name, "_no_done"}, done, 1'b0);
            end else begin
                check({vecs[v].name, "_pt"}, plaintext, vecs[v].pt);
                check({vecs[v].name, "_key"}, key, vecs[v].key);
                check({vecs[v].name, "_start_lat"},
                      (lat >= SYNC + 1 && lat <= SYNC + 2), 1'b1);
            end
        end

        // sck activity in WAIT is ignored, then core result and full readout
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        check("wait_sck_pt", plaintext, FIPS_PT);
        check("wait_sck_done", done, 1'b0);
        deliver(FIPS_CT);
        read_ct(got);
        check("readout_fips", got, FIPS_CT);
        for (int i = 0; i < 3; i++) begin
            send_bit(1'b0);
            tick(4);
            check("sdo_after_extra_sck", sdo, 1'b0);
        end
        check("done_held_in_send", done, 1'b1);
        check("pt_held_in_send", plaintext, FIPS_PT);
        check("key_held_in_send", key, FIPS_KEY);

        // Reset at bit 100 of a new frame
        s0   = start_cnt;
        load = 1'b1;
        tick(6);
        check("done_cleared_on_load", done, 1'b0);
        for (int i = 0; i < 100; i++) send_bit(C1_PT[127-i]);
        reset = 1'b1;
        tick(1);
        check("midrst_sdo", sdo, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_rx_err", rx_err, 1'b0);
        check("midrst_core_start", core_start, 1'b0);
        check("midrst_plaintext", plaintext, 128'h0);
        check("midrst_key", key, 128'h0);
        load = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(6);
        check("midrst_no_start", 256'(start_cnt - s0), 256'(0));
        s0 = start_cnt;
        load_frame({C1_PT, C1_KEY}, 256, 1'b0, lat);
        check("after_rst_starts", 256'(start_cnt - s0), 256'(1));
        check("after_rst_pt", plaintext, C1_PT);
        check("after_rst_key", key, C1_KEY);

        // load rises in WAIT: late core_done is dropped, new frame received
        load = 1'b1;
        tick(6);
        core_done = 1'b1;
        core_ct   = C1_CT;
        tick(1);
        core_done = 1'b0;
        tick(4);
        check("abort_done_low", done, 1'b0);
        check("abort_sdo_low", sdo, 1'b0);
        s0 = start_cnt;
        load_frame({FIPS_PT, FIPS_KEY}, 256, 1'b0, lat);
        check("abort_new_starts", 256'(start_cnt - s0), 256'(1));
        check("abort_new_rx_err", rx_err, 1'b0);
        check("abort_new_pt", plaintext, FIPS_PT);
        check("abort_new_key", key, FIPS_KEY);
        deliver(C1_CT);
        read_ct(got);
        check("readout_c1", got, C1_CT);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
